i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//  I2C target (responder) with a small byte register file. It lets an external host controller configure and poll
//  the FDA board over the same two-wire protocol that I2C_Comm drives as initiator toward the trigger DAC.
//  SCL/SDA are oversampled on the system clock. SDA is driven open-drain via sda_oe. Writes produce
//  strobes toward Main_FSM-side settings logic.
// PARAMETERS
//  ADDR        7'h2A  7-bit target address this block answers to
//  NUM_REGS    8      register count, power of 2, 2..16; pointer width PW = log2(NUM_REGS)
//  FILTER_LEN  3      consecutive equal samples (post-sync) required to accept a new SCL/SDA level
// PORTS
//  clk        in   1            system clock (100 MHz domain, same as Main_FSM)
//  reset_n    in   1            asynchronous active-low reset
//  scl_in     in   1            raw SCL pad input, asynchronous
//  sda_in     in   1            raw SDA pad input, asynchronous
//  sda_oe     out  1            1 = pull SDA low; 0 = release (pad tristate at top level)
//  regs_flat  out  8*NUM_REGS   register file, reg[i] = regs_flat[8*i+7:8*i]
//  wr_strobe  out  1            one-cycle pulse when a data byte is committed to reg[wr_addr]
//  wr_addr    out  PW           register index of the last committed write
//  busy       out  1            1 from accepted START to STOP/idle
// BEHAVIOUR
//  Reset: sda_oe=0, regs_flat=0, wr_strobe=0, wr_addr=0, busy=0, ptr=0, state=IDLE.
//  Input path: 2-flop synchronizer, then glitch filter. Filtered level changes only after FILTER_LEN equal samples.
//  Edge detection runs on filtered signals only:
//   - SCL rise, SCL fall.
//   - START: SDA fall while SCL=1. STOP: SDA rise while SCL=1.
//  Bit timing:
//   - Data is sampled on the filtered SCL rise, MSB first.
//   - sda_oe changes only on the cycle after a filtered SCL fall; never while SCL=1.
//  States:
//   - IDLE: wait for START.
//   - ADDR: shift 8 bits. Address match -> ADDR_ACK. No match -> IDLE, with no ACK driven.
//   - ADDR_ACK: on the SCL fall after the 8th bit, drive ACK (sda_oe=1); release on the next fall.
//     Then R/W=0 -> WR_PTR, R/W=1 -> RD_DATA.
//   - WR_PTR: 8 bits. ptr <= byte[PW-1:0]; upper bits are ignored. ACK, then -> WR_DATA.
//   - WR_DATA: 8 bits, then ACK. On the 8th SCL rise:
//     - reg[ptr] <= byte, wr_addr <= ptr, and wr_strobe pulses 1 cycle.
//     - ptr <= ptr+1 (wrap at NUM_REGS).
//   - RD_DATA: load shifter with reg[ptr] at the ACK-release fall.
//     - Present bit7 at that fall, then the next bit on each fall; sda_oe = ~bit.
//     - Release SDA after the 8th bit; ptr <= ptr+1 (wrap).
//   - RD_ACK: sample the master bit on the 9th rise.
//     - 0 -> RD_DATA, reloading at the next fall.
//     - 1 (NACK) -> WAIT, with SDA released.
//   - WAIT: ignore the bus until START or STOP.
//  START in any state, including mid-byte (repeated start), aborts the current byte:
//   - sda_oe=0, bit count cleared, -> ADDR.
//   - ptr is retained, so write-ptr then repeated-start read works.
//  STOP in any state -> IDLE, sda_oe=0, busy=0. A partial write byte is discarded (no strobe).
//  reset_n asserted mid-transfer: SDA released within the reset assertion; all state per reset list.
//  busy: set on the START cycle, cleared on STOP or on return to IDLE from an address mismatch.
//  Max SCL 400 kHz; at the 100 MHz clk every phase spans far more than FILTER_LEN+2 cycles.
// TESTING
//  1 Write 0x2A<<1|0, ptr 0x03, data 0x5A, STOP -> three ACKs; reg[3]=0x5A; one wr_strobe with wr_addr=3; busy=0 after STOP.
//  2 Write ptr 0x07, data 0x11,0x22 -> reg[7]=0x11, reg[0]=0x22 (wrap); two strobes, wr_addr 7 then 0.
//  3 Write ptr 0x01, repeated START, addr|1, read 3 bytes (ACK,ACK,NACK), STOP with reg[1..3]=A1,B2,C3
//    -> SDA shows A1,B2,C3; sda_oe=0 after NACK.
//  4 Address 0x2B -> no ACK (sda_oe stays 0 all 9th bit); regs unchanged; busy=0 after byte.
//  5 STOP after 5 data bits of a write -> no wr_strobe, reg unchanged; 1-cycle SDA glitch with SCL high -> no START/STOP.
//  6 reset_n low while target drives ACK -> sda_oe=0 immediately; regs_flat=0; next START+valid address ACKs normally.

Source files
------------

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing a byte register file, with filtered SCL/SDA and open-drain SDA.
module i2c_target_regs #(
  parameter logic [6:0] ADDR = 7'h2A,
  parameter int NUM_REGS = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic [8*NUM_REGS-1:0]       regs_flat,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic                        busy
);
  localparam int PW = $clog2(NUM_REGS);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ACK, S_WR_PTR, S_WR_DATA, S_RD_DATA, S_RD_ACK, S_WAIT} state_t;
  state_t state, nxt;
  logic [1:0] raw, meta, syn, filt, filt_q;
  logic [FW-1:0] fcnt [2];
  logic scl, sda, rise, fall, start, stop, ak;
  logic [3:0] cnt;
  logic [7:0] sh, rx, cur;
  logic [PW-1:0] ptr;
  assign raw = {sda_in, scl_in};
  // Bit 0 is SCL, bit 1 is SDA; both idle high
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      meta <= '1;
      syn <= '1;
      filt <= '1;
      filt_q <= '1;
      fcnt <= '{default: '0};
    end else begin
      meta <= raw;
      syn <= meta;
      filt_q <= filt;
      for (int i = 0; i < 2; i++)
        if (syn[i] == filt[i]) fcnt[i] <= '0;
        else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= syn[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + 1'b1;
    end
  assign scl = filt[0];
  assign sda = filt[1];
  assign rise = scl & ~filt_q[0];
  assign fall = ~scl & filt_q[0];
  assign start = scl & filt_q[0] & filt_q[1] & ~sda;
  assign stop = scl & filt_q[0] & ~filt_q[1] & sda;
  assign rx = {sh[6:0], sda};
  assign cur = regs_flat[{ptr, 3'b000} +: 8];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      nxt <= S_IDLE;
      cnt <= '0;
      ak <= 1'b0;
      sh <= '0;
      ptr <= '0;
      sda_oe <= 1'b0;
      regs_flat <= '0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      busy <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
        cnt <= '0;
        ak <= 1'b0;
      end else if (start) begin
        state <= S_ADDR;
        sda_oe <= 1'b0;
        busy <= 1'b1;
        cnt <= '0;
        ak <= 1'b0;
      end else
        case (state)
          S_ADDR, S_WR_PTR, S_WR_DATA:
            if (rise) begin
              sh <= rx;
              cnt <= (cnt == 4'd7) ? '0 : cnt + 4'd1;
              if (cnt == 4'd7) begin
                state <= S_ACK;
                nxt <= S_WR_DATA;
                if (state == S_ADDR) begin
                  nxt <= rx[0] ? S_RD_DATA : S_WR_PTR;
                  if (rx[7:1] != ADDR) begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                  end
                end else if (state == S_WR_PTR) ptr <= rx[PW-1:0];
                else begin
                  regs_flat[{ptr, 3'b000} +: 8] <= rx;
                  wr_addr <= ptr;
                  wr_strobe <= 1'b1;
                  ptr <= ptr + 1'b1;
                end
              end
            end
          // First fall drives ACK, second fall releases it or presents read bit 7
          S_ACK:
            if (fall) begin
              ak <= ~ak;
              sda_oe <= ~ak;
              if (ak) begin
                state <= nxt;
                cnt <= '0;
                if (nxt == S_RD_DATA) begin
                  sh <= cur;
                  sda_oe <= ~cur[7];
                end
              end
            end
          S_RD_DATA:
            if (rise) begin
              sh <= {sh[6:0], 1'b0};
              cnt <= cnt + 4'd1;
            end else if (fall) begin
              sda_oe <= (cnt == 4'd8) ? 1'b0 : ~sh[7];
              if (cnt == 4'd8) begin
                state <= S_RD_ACK;
                ptr <= ptr + 1'b1;
                cnt <= '0;
              end
            end
          S_RD_ACK:
            if (rise) begin
              if (sda) state <= S_WAIT;
              else ak <= 1'b1;
            end else if (fall && ak) begin
              ak <= 1'b0;
              state <= S_RD_DATA;
              sh <= cur;
              sda_oe <= ~cur[7];
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level I2C master driving the target; a scoreboard checks write strobes and read bytes.
module tb_i2c_target_regs;
  localparam int Q = 12;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, wr_strobe, busy;
  logic [63:0] regs_flat;
  logic [2:0] wr_addr;
  wire sda_line = sda_m & ~sda_oe;
  int vectors = 0;
  int miscompares = 0;
  logic [10:0] wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] shadow [8];
  logic [10:0] e;
  logic oe_prev = 1'b0;
  always #5 clk = ~clk;
  i2c_target_regs dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
  );
  always @(negedge clk) begin
    if (reset_n && sda_oe !== oe_prev && scl) begin
      miscompares++;
      $display("FAIL oe_stable_scl_high: sda_oe went %b while scl=1, required no change", sda_oe);
    end
    oe_prev = sda_oe;
    if (wr_strobe) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected: wr_addr=%0d data=%h, required no strobe", wr_addr, regs_flat[{wr_addr, 3'b000} +: 8]);
      end else begin
        e = wr_q.pop_front();
        if ({wr_addr, regs_flat[{wr_addr, 3'b000} +: 8]} !== e) begin
          miscompares++;
          $display("FAIL strobe_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, regs_flat[{wr_addr, 3'b000} +: 8], e[10:8], e[7:0]);
        end
      end
    end
  end
  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  function automatic logic [63:0] flat();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = shadow[i];
    return r;
  endfunction
  task automatic q();
    repeat (Q) @(negedge clk);
  endtask
  task automatic expect_write(input logic [2:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    shadow[a] = d;
  endtask
  task automatic start_cond();
    sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
  endtask
  task automatic stop_cond();
    sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
  endtask
  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b; q(); scl = 1'b1; q();
    if (glitch) begin
      sda_m = ~b;
      @(negedge clk);
      sda_m = b;
    end
    q(); scl = 1'b0; q();
  endtask
  task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack, output logic oe_any);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
    sda_m = 1'b1;
    oe_any = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 4*Q; i++) begin
      if (i == Q) scl = 1'b1;
      if (i == 2*Q) ack = !sda_line;
      if (i == 3*Q) scl = 1'b0;
      @(negedge clk);
      oe_any |= sda_oe;
    end
  endtask
  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; q(); scl = 1'b1; q();
      d[i] = sda_line;
      q(); scl = 1'b0; q();
    end
    send_bit(nack, 1'b0);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    repeat (4) @(negedge clk);
    vectors++;
    if ({sda_oe, wr_strobe, busy, wr_addr, regs_flat} !== 70'd0) begin
      miscompares++;
      $display("FAIL reset_state: oe=%b strobe=%b busy=%b addr=%0d regs=%h, required all 0",
               sda_oe, wr_strobe, busy, wr_addr, regs_flat);
    end
    reset_n = 1'b1;
    q();
  endtask
  task automatic test_write();
    logic a0, a1, a2, o;
    start_cond();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_start: got %b, required 1", busy); end
    send_byte(8'h54, -1, a0, o);
    send_byte(8'h03, -1, a1, o);
    expect_write(3'd3, 8'h5A);
    send_byte(8'h5A, -1, a2, o);
    stop_cond();
    vectors++;
    if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL write_acks: got %b, required 111", {a0, a1, a2}); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_stop: got %b, required 0", busy); end
    vectors++;
    if (regs_flat !== flat()) begin miscompares++; $display("FAIL write_regs: got %h, required %h", regs_flat, flat()); end
    vectors++;
    if (wr_q.size() != 0) begin miscompares++; $display("FAIL write_strobes: %0d strobes missing, required 0", wr_q.size()); end
  endtask
  task automatic test_wrap();
    logic a0, a1, a2, a3, o;
    start_cond();
    send_byte(8'h54, -1, a0, o);
    send_byte(8'h07, -1, a1, o);
    expect_write(3'd7, 8'h11);
    send_byte(8'h11, -1, a2, o);
    expect_write(3'd0, 8'h22);
    send_byte(8'h22, -1, a3, o);
    stop_cond();
    vectors++;
    if ({a0, a1, a2, a3} !== 4'b1111) begin miscompares++; $display("FAIL wrap_acks: got %b, required 1111", {a0, a1, a2, a3}); end
    vectors++;
    if (regs_flat !== flat()) begin miscompares++; $display("FAIL wrap_regs: got %h, required %h", regs_flat, flat()); end
    vectors++;
    if (wr_q.size() != 0) begin miscompares++; $display("FAIL wrap_strobes: %0d strobes missing, required 0", wr_q.size()); end
  endtask
  task automatic test_read();
    logic [5:0] a;
    logic o;
    logic [7:0] d, x;
    start_cond();
    send_byte(8'h54, -1, a[0], o);
    send_byte(8'h01, -1, a[1], o);
    expect_write(3'd1, 8'hA1); send_byte(8'hA1, -1, a[2], o);
    expect_write(3'd2, 8'hB2); send_byte(8'hB2, -1, a[3], o);
    expect_write(3'd3, 8'hC3); send_byte(8'hC3, -1, a[4], o);
    stop_cond();
    start_cond();
    send_byte(8'h54, -1, a[5], o);
    vectors++;
    if (a !== 6'h3F) begin miscompares++; $display("FAIL read_setup_acks: got %b, required 111111", a); end
    send_byte(8'h01, -1, a[0], o);
    start_cond();
    send_byte(8'h55, -1, a[1], o);
    vectors++;
    if (a[1:0] !== 2'b11) begin miscompares++; $display("FAIL read_addr_acks: got %b, required 11", a[1:0]); end
    for (int i = 1; i <= 3; i++) begin
      rd_q.push_back(shadow[i]);
      read_byte(d, i == 3);
      x = rd_q.pop_front();
      vectors++;
      if (d !== x) begin miscompares++; $display("FAIL read_byte%0d: got %h, required %h", i, d, x); end
    end
    vectors++;
    if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL read_nack_release: sda_oe=%b, required 0", sda_oe); end
    stop_cond();
    start_cond();
    send_byte(8'h55, -1, a[0], o);
    rd_q.push_back(shadow[4]);
    read_byte(d, 1'b1);
    stop_cond();
    x = rd_q.pop_front();
    vectors++;
    if ({a[0], d} !== {1'b1, x}) begin miscompares++; $display("FAIL read_ptr_advance: ack=%b data=%h, required ack=1 data=%h", a[0], d, x); end
  endtask
  task automatic test_bad_addr();
    logic a, o;
    start_cond();
    send_byte(8'h56, -1, a, o);
    vectors++;
    if ({a, o} !== 2'b00) begin miscompares++; $display("FAIL bad_addr_ack: ack=%b oe_seen=%b, required 0 0", a, o); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_addr_busy: got %b, required 0", busy); end
    send_byte(8'h02, -1, a, o);
    send_byte(8'hEE, -1, a, o);
    stop_cond();
    vectors++;
    if (regs_flat !== flat()) begin miscompares++; $display("FAIL bad_addr_regs: got %h, required %h", regs_flat, flat()); end
  endtask
  task automatic test_stop_abort();
    logic [3:0] a;
    logic o;
    start_cond();
    send_byte(8'h54, -1, a[0], o);
    send_byte(8'h04, -1, a[1], o);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    stop_cond();
    vectors++;
    if ({a[1:0], busy} !== 3'b110) begin miscompares++; $display("FAIL abort_state: acks=%b busy=%b, required 11 0", a[1:0], busy); end
    vectors++;
    if (regs_flat !== flat()) begin miscompares++; $display("FAIL abort_regs: got %h, required %h", regs_flat, flat()); end
    q();
    sda_m = 1'b0;
    @(negedge clk);
    sda_m = 1'b1;
    q();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_glitch_busy: got %b, required 0", busy); end
    start_cond();
    send_byte(8'h54, -1, a[0], o);
    send_byte(8'h05, -1, a[1], o);
    expect_write(3'd5, 8'h3C);
    send_byte(8'h3C, 4, a[2], o);
    expect_write(3'd6, 8'hC3);
    send_byte(8'hC3, 5, a[3], o);
    vectors++;
    if ({a, busy} !== 5'b11111) begin miscompares++; $display("FAIL glitch_xfer: acks=%b busy=%b, required 1111 1", a, busy); end
    stop_cond();
    vectors++;
    if (regs_flat !== flat() || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_regs: got %h pending=%0d, required %h pending=0", regs_flat, wr_q.size(), flat());
    end
  endtask
  task automatic test_reset_mid();
    logic a, o;
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i[0] ^ i[1] ? 1'b0 : 1'b0, 1'b0);
    stop_cond();
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(8'h54 >> i & 1, 1'b0);
    sda_m = 1'b1;
    vectors++;
    if (sda_oe !== 1'b1) begin miscompares++; $display("FAIL mid_ack_driven: sda_oe=%b, required 1", sda_oe); end
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    vectors++;
    if ({sda_oe, busy, regs_flat} !== 66'd0) begin
      miscompares++;
      $display("FAIL mid_reset: oe=%b busy=%b regs=%h, required 0 0 0", sda_oe, busy, regs_flat);
    end
    @(negedge clk);
    scl = 1'b1;
    q();
    reset_n = 1'b1;
    q();
    start_cond();
    send_byte(8'h54, -1, a, o);
    stop_cond();
    vectors++;
    if ({a, busy, regs_flat} !== {1'b1, 1'b0, flat()}) begin
      miscompares++;
      $display("FAIL after_reset_ack: ack=%b busy=%b regs=%h, required 1 0 %h", a, busy, regs_flat, flat());
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_read();
    test_bad_addr();
    test_stop_abort();
    test_reset_mid();
    q();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
